// File: rtl/addr_xlate_pkg.sv
// Shared types for the address translation unit: CSR window layout, micro-TLB
// entry, FSM states, registered response and TLB fault classification.
package addr_xlate_pkg;

  typedef struct packed {
    logic [2:0]  vseg;
    logic        rsv28;
    logic [2:0]  pseg;
    logic [18:0] rsv24_6;
    logic [1:0]  mat;
    logic [3:0]  plv_en;
  } dmw_t;

  typedef struct packed {
    logic        valid;
    logic [19:0] vppn;
    logic [19:0] pfn;
    logic [1:0]  mat;
  } utlb_entry_t;

  typedef enum logic [1:0] {IDLE, TLB_WAIT, DRAIN} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] paddr;
    logic [1:0]  mat;
    logic        is_dmw;
    logic        is_tlb;
    logic        refill;
    logic        pinv;
    logic        ppi;
  } xlate_rsp_t;

  localparam logic [1:0] FLT_NONE   = 2'd0;
  localparam logic [1:0] FLT_REFILL = 2'd1;
  localparam logic [1:0] FLT_PINV   = 2'd2;
  localparam logic [1:0] FLT_PPI    = 2'd3;

  // Fault precedence: missing page, then invalid page, then privilege.
  function automatic logic [1:0] tlb_fault(input logic found, input logic v,
                                           input logic [1:0] cur_plv,
                                           input logic [1:0] page_plv);
    if (!found)                 return FLT_REFILL;
    else if (!v)                return FLT_PINV;
    else if (cur_plv > page_plv) return FLT_PPI;
    else                        return FLT_NONE;
  endfunction

endpackage

// File: rtl/addr_xlate_if.sv
// Request, response and shared-TLB lookup signals of the translation unit.
// slave is the translator's view, master the AGU/cache/TLB side.
interface addr_xlate_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;

  logic        tlb_req_valid;
  logic [19:0] tlb_req_vppn;
  logic        tlb_rsp_valid;
  logic        tlb_rsp_found;
  logic        tlb_rsp_v;
  logic [1:0]  tlb_rsp_plv;
  logic [1:0]  tlb_rsp_mat;
  logic [19:0] tlb_rsp_pfn;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_paddr;
  logic [1:0]  rsp_mat;
  logic        rsp_is_dmw;
  logic        rsp_is_tlb;
  logic        rsp_refill;
  logic        rsp_pinv;
  logic        rsp_ppi;

  modport slave (
    input  req_valid, req_vaddr, rsp_ready,
           tlb_rsp_valid, tlb_rsp_found, tlb_rsp_v, tlb_rsp_plv, tlb_rsp_mat, tlb_rsp_pfn,
    output req_ready, tlb_req_valid, tlb_req_vppn,
           rsp_valid, rsp_paddr, rsp_mat, rsp_is_dmw, rsp_is_tlb, rsp_refill, rsp_pinv, rsp_ppi
  );

  modport master (
    output req_valid, req_vaddr, rsp_ready,
           tlb_rsp_valid, tlb_rsp_found, tlb_rsp_v, tlb_rsp_plv, tlb_rsp_mat, tlb_rsp_pfn,
    input  req_ready, tlb_req_valid, tlb_req_vppn,
           rsp_valid, rsp_paddr, rsp_mat, rsp_is_dmw, rsp_is_tlb, rsp_refill, rsp_pinv, rsp_ppi
  );
endinterface

// File: rtl/addr_xlate_unit_utlb.sv
// Fully-associative micro-TLB: parallel lookup, flush-all, round-robin fill.
// Flush wins over a fill presented in the same cycle.
module utlb_array
  import addr_xlate_pkg::*;
#(
  parameter int ENTRIES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [19:0] lk_vppn,
  output logic        lk_hit,
  output logic [19:0] lk_pfn,
  output logic [1:0]  lk_mat,
  input  logic        fill_en,
  input  logic [19:0] fill_vppn,
  input  logic [19:0] fill_pfn,
  input  logic [1:0]  fill_mat
);
  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  utlb_entry_t [ENTRIES-1:0] ent_q, ent_d;
  logic [PW-1:0]             ptr_q, ptr_d;

  always_comb begin
    lk_hit = 1'b0;
    lk_pfn = '0;
    lk_mat = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!lk_hit && ent_q[i].valid && ent_q[i].vppn == lk_vppn) begin
        lk_hit = 1'b1;
        lk_pfn = ent_q[i].pfn;
        lk_mat = ent_q[i].mat;
      end
    end
  end

  always_comb begin
    ent_d = ent_q;
    ptr_d = ptr_q;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent_d[i].valid = 1'b0;
    end else if (fill_en) begin
      ent_d[ptr_q] = '{valid: 1'b1, vppn: fill_vppn, pfn: fill_pfn, mat: fill_mat};
      ptr_d        = (ptr_q == PW'(ENTRIES - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ent_q <= '0;
      ptr_q <= '0;
    end else begin
      ent_q <= ent_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/addr_xlate_unit.sv
// Pipelined virtual-to-physical translator: DA mode, prioritised DMW windows,
// micro-TLB hit in one cycle, shared-TLB lookup and refill on a miss.
module addr_xlate_unit
  import addr_xlate_pkg::*;
#(
  parameter int NUM_DMW      = 2,
  parameter int UTLB_ENTRIES = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  addr_xlate_if.slave             bus,
  input  logic                    csr_da,
  input  logic                    csr_pg,
  input  logic [1:0]              csr_plv,
  input  logic [1:0]              csr_datm,
  input  logic [NUM_DMW-1:0][31:0] csr_dmw,
  input  logic                    utlb_flush,
  input  logic                    cancel
);
  state_t      state_q, state_d;
  xlate_rsp_t  rsp_q, rsp_d;
  logic        tlb_req_q, tlb_req_d;
  logic [19:0] vppn_q, vppn_d;
  logic [11:0] voff_q, voff_d;
  logic [1:0]  plv_q, plv_d;
  logic        flush_seen_q, flush_seen_d;

  logic        req_ready, accept, fill_en;
  logic        lk_hit, utlb_hit;
  logic [19:0] lk_pfn;
  logic [1:0]  lk_mat, fault;

  logic [NUM_DMW-1:0]      dmw_hit;
  logic [NUM_DMW-1:0][2:0] dmw_pseg;
  logic [NUM_DMW-1:0][1:0] dmw_mat;
  logic [NUM_DMW-1:0]      unused_dmw_rsv;
  logic                    dmw_any;
  logic [2:0]              dmw_sel_pseg;
  logic [1:0]              dmw_sel_mat;

  for (genvar i = 0; i < NUM_DMW; i++) begin : g_dmw
    dmw_t w;
    assign w                 = dmw_t'(csr_dmw[i]);
    assign dmw_hit[i]        = (w.vseg == bus.req_vaddr[31:29]) && w.plv_en[csr_plv];
    assign dmw_pseg[i]       = w.pseg;
    assign dmw_mat[i]        = w.mat;
    assign unused_dmw_rsv[i] = ^{w.rsv28, w.rsv24_6};
  end

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    dmw_any      = 1'b0;
    dmw_sel_pseg = '0;
    dmw_sel_mat  = '0;
    for (int i = NUM_DMW - 1; i >= 0; i--) begin
      if (dmw_hit[i]) begin
        dmw_any      = 1'b1;
        dmw_sel_pseg = dmw_pseg[i];
        dmw_sel_mat  = dmw_mat[i];
      end
    end
  end

  utlb_array #(.ENTRIES(UTLB_ENTRIES)) u_utlb (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (utlb_flush),
    .lk_vppn   (bus.req_vaddr[31:12]),
    .lk_hit    (lk_hit),
    .lk_pfn    (lk_pfn),
    .lk_mat    (lk_mat),
    .fill_en   (fill_en),
    .fill_vppn (vppn_q),
    .fill_pfn  (bus.tlb_rsp_pfn),
    .fill_mat  (bus.tlb_rsp_mat)
  );

  // A flush in the accept cycle must make the lookup miss.
  assign utlb_hit  = lk_hit && !utlb_flush;
  assign req_ready = (state_q == IDLE) && (!rsp_q.valid || bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;
  assign fault     = tlb_fault(bus.tlb_rsp_found, bus.tlb_rsp_v, plv_q, bus.tlb_rsp_plv);

  always_comb begin
    state_d      = state_q;
    rsp_d        = rsp_q;
    tlb_req_d    = 1'b0;
    vppn_d       = vppn_q;
    voff_d       = voff_q;
    plv_d        = plv_q;
    flush_seen_d = flush_seen_q;
    fill_en      = 1'b0;
    if (rsp_q.valid && bus.rsp_ready) rsp_d.valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cancel) begin
          rsp_d = '0;
        end else if (accept) begin
          rsp_d  = '0;
          vppn_d = bus.req_vaddr[31:12];
          voff_d = bus.req_vaddr[11:0];
          plv_d  = csr_plv;
          if (csr_da && !csr_pg) begin
            rsp_d.valid = 1'b1;
            rsp_d.paddr = bus.req_vaddr;
            rsp_d.mat   = csr_datm;
          end else if (dmw_any) begin
            rsp_d.valid  = 1'b1;
            rsp_d.paddr  = {dmw_sel_pseg, bus.req_vaddr[28:0]};
            rsp_d.mat    = dmw_sel_mat;
            rsp_d.is_dmw = 1'b1;
          end else if (utlb_hit) begin
            rsp_d.valid  = 1'b1;
            rsp_d.paddr  = {lk_pfn, bus.req_vaddr[11:0]};
            rsp_d.mat    = lk_mat;
            rsp_d.is_tlb = 1'b1;
          end else begin
            state_d      = TLB_WAIT;
            tlb_req_d    = 1'b1;
            flush_seen_d = 1'b0;
          end
        end
      end
      TLB_WAIT: begin
        if (utlb_flush) flush_seen_d = 1'b1;
        if (bus.tlb_rsp_valid) begin
          state_d = IDLE;
          // A cancel landing with the lookup result kills it like a drain.
          if (!cancel) begin
            rsp_d.valid  = 1'b1;
            rsp_d.paddr  = {bus.tlb_rsp_pfn, voff_q};
            rsp_d.mat    = bus.tlb_rsp_mat;
            rsp_d.is_tlb = 1'b1;
            rsp_d.refill = (fault == FLT_REFILL);
            rsp_d.pinv   = (fault == FLT_PINV);
            rsp_d.ppi    = (fault == FLT_PPI);
            fill_en      = (fault == FLT_NONE) && !flush_seen_q && !utlb_flush;
          end
        end else if (cancel) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.tlb_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      rsp_q        <= '0;
      tlb_req_q    <= 1'b0;
      vppn_q       <= '0;
      voff_q       <= '0;
      plv_q        <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_q        <= rsp_d;
      tlb_req_q    <= tlb_req_d;
      vppn_q       <= vppn_d;
      voff_q       <= voff_d;
      plv_q        <= plv_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.tlb_req_valid = tlb_req_q;
  assign bus.tlb_req_vppn  = vppn_q;
  assign bus.rsp_valid     = rsp_q.valid;
  assign bus.rsp_paddr     = rsp_q.paddr;
  assign bus.rsp_mat       = rsp_q.mat;
  assign bus.rsp_is_dmw    = rsp_q.is_dmw;
  assign bus.rsp_is_tlb    = rsp_q.is_tlb;
  assign bus.rsp_refill    = rsp_q.refill;
  assign bus.rsp_pinv      = rsp_q.pinv;
  assign bus.rsp_ppi       = rsp_q.ppi;

endmodule
